// File: rtl/ppu_sprite_pixel_fsm.sv
// ppu_sprite_pixel_fsm
//   Fetches pattern-table bit planes for two sprite slots on a start pulse,
//   then resolves the sprite pixel for curr_col every cycle (1-cycle latency).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   curr_row, curr_col       raster position (9 bits each)
//   sprite_{0,1}_*           slot on_tile/tile_num/row/col/attr
//   sprite_colors            16 palette bytes, entry k at [8k+7:8k]
//   vram_read_addr/data      pattern fetch port, data 1 cycle after address
//   pix_start, pix_busy      fetch handshake
//   pix_valid/color/behind_bg/is_sprite0   resolved sprite pixel
module ppu_sprite_pixel_fsm #(
  parameter int              ADDR_W  = 16,
  parameter logic [ADDR_W-1:0] PT_BASE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [8:0]        curr_row,
  input  logic [8:0]        curr_col,
  input  logic              sprite_0_on_tile,
  input  logic [7:0]        sprite_0_tile_num,
  input  logic [7:0]        sprite_0_row,
  input  logic [7:0]        sprite_0_col,
  input  logic [7:0]        sprite_0_attr,
  input  logic              sprite_1_on_tile,
  input  logic [7:0]        sprite_1_tile_num,
  input  logic [7:0]        sprite_1_row,
  input  logic [7:0]        sprite_1_col,
  input  logic [7:0]        sprite_1_attr,
  input  logic [127:0]      sprite_colors,
  output logic [ADDR_W-1:0] vram_read_addr,
  input  logic [7:0]        vram_read_data,
  input  logic              pix_start,
  output logic              pix_busy,
  output logic              pix_valid,
  output logic [7:0]        pix_color,
  output logic              pix_behind_bg,
  output logic              pix_is_sprite0
);

  localparam int NUM_SLOTS = 2;

  typedef enum logic [2:0] {IDLE, F0L, F0H, F1L, F1H, CAP} state_t;
  state_t state, state_nxt;

  // slot inputs repacked so per-slot logic can live in a generate loop
  logic [NUM_SLOTS-1:0]            s_on;
  logic [NUM_SLOTS-1:0][7:0]       s_tile, s_row, s_col, s_attr;
  assign s_on   = {sprite_1_on_tile,  sprite_0_on_tile};
  assign s_tile = {sprite_1_tile_num, sprite_0_tile_num};
  assign s_row  = {sprite_1_row,      sprite_0_row};
  assign s_col  = {sprite_1_col,      sprite_0_col};
  assign s_attr = {sprite_1_attr,     sprite_0_attr};

  logic unused_attr_bits;
  assign unused_attr_bits = ^{sprite_0_attr[4:2], sprite_1_attr[4:2]};

  // state latched at pix_start
  logic [NUM_SLOTS-1:0]              lt_on;
  logic [NUM_SLOTS-1:0][7:0]         lt_col;
  logic [NUM_SLOTS-1:0][7:0]         lt_attr;
  logic [NUM_SLOTS-1:0][ADDR_W-1:0]  lt_addr;   // low-plane address
  logic [NUM_SLOTS-1:0][7:0]         lo_pl, hi_pl;

  logic [NUM_SLOTS-1:0][ADDR_W-1:0]  start_addr;
  logic [NUM_SLOTS-1:0]              hit;
  logic [NUM_SLOTS-1:0][1:0]         pv;

  for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
    logic [2:0] dy_raw, dy;
    logic [8:0] dx;
    logic [2:0] b;
    logic       in_rng;

    // only the low 3 bits of the row difference select the tile line
    assign dy_raw        = 3'(curr_row - {1'b0, s_row[s]});
    assign dy            = s_attr[s][7] ? ~dy_raw : dy_raw;   // 7-dy
    assign start_addr[s] = PT_BASE + ADDR_W'({s_tile[s], 4'b0000}) + ADDR_W'(dy);

    // 9-bit compare: sprites near the right edge run past 255 without wrapping
    assign dx     = curr_col - {1'b0, lt_col[s]};
    assign in_rng = (curr_col >= {1'b0, lt_col[s]}) && (dx < 9'd8);
    assign b      = lt_attr[s][6] ? dx[2:0] : ~dx[2:0];
    assign pv[s]  = {hi_pl[s][b], lo_pl[s][b]};
    assign hit[s] = in_rng && (pv[s] != 2'b00);
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    vram_read_addr = '0;
    case (state)
      IDLE: if (pix_start) state_nxt = F0L;
      F0L: begin state_nxt = F0H; vram_read_addr = lt_addr[0]; end
      F0H: begin state_nxt = F1L; vram_read_addr = lt_addr[0] + ADDR_W'(8); end
      F1L: begin state_nxt = F1H; vram_read_addr = lt_addr[1]; end
      F1H: begin state_nxt = CAP; vram_read_addr = lt_addr[1] + ADDR_W'(8); end
      CAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign pix_busy = (state != IDLE);

  // ---------------- latches and plane capture ----------------
  // Data for the address driven in state X arrives in the state after X,
  // so each plane is written while the following state is current.
  always_ff @(posedge clk) begin
    if (rst) begin
      lt_on   <= '0;
      lt_col  <= '0;
      lt_attr <= '0;
      lt_addr <= '0;
      lo_pl   <= '0;
      hi_pl   <= '0;
    end else begin
      if (state == IDLE && pix_start) begin
        lt_on   <= s_on;
        lt_col  <= s_col;
        lt_attr <= s_attr;
        lt_addr <= start_addr;
      end
      case (state)
        F0H: lo_pl[0] <= lt_on[0] ? vram_read_data : 8'h00;
        F1L: hi_pl[0] <= lt_on[0] ? vram_read_data : 8'h00;
        F1H: lo_pl[1] <= lt_on[1] ? vram_read_data : 8'h00;
        CAP: hi_pl[1] <= lt_on[1] ? vram_read_data : 8'h00;
        default: ;
      endcase
    end
  end

  // ---------------- pixel resolve ----------------
  logic       win_sel;     // 0 = slot 0, 1 = slot 1
  logic [3:0] pal_idx;
  logic [7:0] win_color;
  logic       show;

  always_comb begin
    win_sel   = ~hit[0];
    pal_idx   = {lt_attr[win_sel][1:0], pv[win_sel]};
    win_color = sprite_colors[{pal_idx, 3'b000} +: 8];
    // suppress while a fetch is starting or running so half-loaded planes never show
    show      = (state == IDLE) && !pix_start && (|hit);
  end

  always_ff @(posedge clk) begin
    if (rst || !show) begin
      pix_valid      <= 1'b0;
      pix_color      <= 8'h00;
      pix_behind_bg  <= 1'b0;
      pix_is_sprite0 <= 1'b0;
    end else begin
      pix_valid      <= 1'b1;
      pix_color      <= win_color;
      pix_behind_bg  <= lt_attr[win_sel][5];
      pix_is_sprite0 <= ~win_sel;
    end
  end

endmodule
